// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the IF-side, register-file, forwarding and EX-side
// signals of the RV32I decode stage.
//   slave  : view taken by decode_stage (consumes instruction, produces bundle)
//   master : view taken by the surrounding pipeline / testbench
// Ports carried: rdy_in, flush, if_valid/if_pc/if_ins/id_ready,
//   rf_re*/rf_addr*/rf_data*, fwd_we/fwd_rd/fwd_data/fwd_pending,
//   ex_ready/ex_valid and the decoded ex_* bundle.
interface decode_stage_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
);
  logic                      rdy_in;
  logic                      flush;
  logic                      if_valid;
  logic [XLEN-1:0]           if_pc;
  logic [31:0]               if_ins;
  logic                      id_ready;
  logic                      rf_re1;
  logic                      rf_re2;
  logic [REG_AW-1:0]         rf_addr1;
  logic [REG_AW-1:0]         rf_addr2;
  logic [XLEN-1:0]           rf_data1;
  logic [XLEN-1:0]           rf_data2;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd;
  logic [NUM_FWD*XLEN-1:0]   fwd_data;
  logic [NUM_FWD-1:0]        fwd_pending;
  logic                      ex_ready;
  logic                      ex_valid;
  logic [XLEN-1:0]           ex_pc;
  logic [REG_AW-1:0]         ex_rs1;
  logic [REG_AW-1:0]         ex_rs2;
  logic [XLEN-1:0]           ex_op1;
  logic [XLEN-1:0]           ex_op2;
  logic [REG_AW-1:0]         ex_rd;
  logic [XLEN-1:0]           ex_imm;
  logic [6:0]                ex_opcode;
  logic [2:0]                ex_funct3;
  logic                      ex_diff;
  logic                      ex_illegal;

  modport slave (
    input  rdy_in, flush, if_valid, if_pc, if_ins,
    output id_ready,
    output rf_re1, rf_re2, rf_addr1, rf_addr2,
    input  rf_data1, rf_data2,
    input  fwd_we, fwd_rd, fwd_data, fwd_pending,
    input  ex_ready,
    output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_op1, ex_op2, ex_rd, ex_imm,
    output ex_opcode, ex_funct3, ex_diff, ex_illegal
  );

  modport master (
    output rdy_in, flush, if_valid, if_pc, if_ins,
    input  id_ready,
    input  rf_re1, rf_re2, rf_addr1, rf_addr2,
    output rf_data1, rf_data2,
    output fwd_we, fwd_rd, fwd_data, fwd_pending,
    output ex_ready,
    input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_op1, ex_op2, ex_rd, ex_imm,
    input  ex_opcode, ex_funct3, ex_diff, ex_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode. Decodes if_ins combinationally, reads
// the register file, resolves operands through NUM_FWD forwarding channels
// (channel 0 youngest, highest priority), stalls on load-use and presents the
// bundle to EX through a valid/ready output register with flush.
//   clk_in : clock
//   rst_in : synchronous active-high reset
//   bus    : decode_stage_if.slave (IF, register file, forwarding, EX)
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic           clk_in,
  input  logic           rst_in,
  decode_stage_if.slave  bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0]       ins;
  logic [6:0]        opcode;
  logic              use1, use2;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm;
  logic [2:0]        funct3;
  logic              diff, illegal;

  assign ins    = bus.if_ins;
  assign opcode = ins[6:0];

  always_comb begin
    use1    = 1'b0;
    use2    = 1'b0;
    rd      = REG_AW'(ins[11:7]);
    imm32   = '0;
    funct3  = ins[14:12];
    diff    = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm32 = {ins[31:12], 12'b0};
      OPC_JAL:   imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      OPC_JALR, OPC_LOAD: begin
        use1  = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_BRANCH: begin
        use1  = 1'b1;
        use2  = 1'b1;
        rd    = '0;
        imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_STORE: begin
        use1  = 1'b1;
        use2  = 1'b1;
        rd    = '0;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OPC_OPIMM: begin
        use1  = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        diff  = ins[30];
      end
      OPC_OP: begin
        use1 = 1'b1;
        use2 = 1'b1;
        diff = ins[30];
      end
      default: begin
        illegal = 1'b1;
        rd      = '0;
        funct3  = '0;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));
  assign rs1 = use1 ? REG_AW'(ins[19:15]) : '0;
  assign rs2 = use2 ? REG_AW'(ins[24:20]) : '0;

  assign bus.rf_re1   = use1;
  assign bus.rf_re2   = use2;
  assign bus.rf_addr1 = rs1;
  assign bus.rf_addr2 = rs2;

  // Channels are scanned oldest-first so the youngest match is written last.
  logic [XLEN-1:0] op1, op2;
  logic            haz1, haz2;

  always_comb begin
    op1  = bus.rf_data1;
    op2  = bus.rf_data2;
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (bus.fwd_we[i] && bus.fwd_rd[i*REG_AW +: REG_AW] == rs1) begin
        op1  = bus.fwd_data[i*XLEN +: XLEN];
        haz1 = bus.fwd_pending[i];
      end
      if (bus.fwd_we[i] && bus.fwd_rd[i*REG_AW +: REG_AW] == rs2) begin
        op2  = bus.fwd_data[i*XLEN +: XLEN];
        haz2 = bus.fwd_pending[i];
      end
    end
    if (rs1 == '0) begin
      op1  = '0;
      haz1 = 1'b0;
    end
    if (rs2 == '0) begin
      op2  = '0;
      haz2 = 1'b0;
    end
  end

  logic ex_valid_q;
  logic slot_free, hazard, take;

  assign slot_free    = !ex_valid_q || bus.ex_ready;
  assign hazard       = bus.if_valid && (haz1 || haz2);
  assign bus.id_ready = !rst_in && bus.rdy_in && !hazard && slot_free;
  assign take         = bus.if_valid && !hazard;

  logic [XLEN-1:0]   pc_q, op1_q, op2_q, imm_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [6:0]        opcode_q;
  logic [2:0]        funct3_q;
  logic              diff_q, illegal_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ex_valid_q <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      diff_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (bus.rdy_in) begin
      if (bus.flush) begin
        ex_valid_q <= 1'b0;
      end else if (slot_free) begin
        // Either a new bundle loads or the slot empties into a bubble.
        ex_valid_q <= take;
        if (take) begin
          pc_q      <= bus.if_pc;
          rs1_q     <= rs1;
          rs2_q     <= rs2;
          op1_q     <= op1;
          op2_q     <= op2;
          rd_q      <= rd;
          imm_q     <= imm;
          opcode_q  <= opcode;
          funct3_q  <= funct3;
          diff_q    <= diff;
          illegal_q <= illegal;
        end
      end
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_pc      = pc_q;
  assign bus.ex_rs1     = rs1_q;
  assign bus.ex_rs2     = rs2_q;
  assign bus.ex_op1     = op1_q;
  assign bus.ex_op2     = op2_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_opcode  = opcode_q;
  assign bus.ex_funct3  = funct3_q;
  assign bus.ex_diff    = diff_q;
  assign bus.ex_illegal = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus a randomized run of decode_stage,
// checked against a behavioural model of the RV32I decode rules and of the
// valid/ready output register.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int NF   = 2;
  localparam int AW   = 5;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  decode_stage_if #(.XLEN(XLEN), .NUM_FWD(NF), .REG_AW(AW)) bus ();
  decode_stage #(.XLEN(XLEN), .NUM_FWD(NF), .REG_AW(AW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  logic        fwe   [NF];
  logic [4:0]  frd   [NF];
  logic [31:0] fdat  [NF];
  logic        fpend [NF];
  logic [31:0] rf_mem[32];

  assign bus.fwd_we      = {fwe[1], fwe[0]};
  assign bus.fwd_rd      = {frd[1], frd[0]};
  assign bus.fwd_data    = {fdat[1], fdat[0]};
  assign bus.fwd_pending = {fpend[1], fpend[0]};
  assign bus.rf_data1    = rf_mem[bus.rf_addr1];
  assign bus.rf_data2    = rf_mem[bus.rf_addr2];

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        diff;
    logic        ill;
  } bundle_t;

  bundle_t act;
  assign act = {bus.ex_pc, bus.ex_rs1, bus.ex_rs2, bus.ex_op1, bus.ex_op2,
                bus.ex_rd, bus.ex_imm, bus.ex_opcode, bus.ex_funct3,
                bus.ex_diff, bus.ex_illegal};

  int n_tests = 0;
  int n_fail  = 0;

  // Operand value for architectural register a given the current channels.
  function automatic void resolve(input logic [4:0] a, output logic haz,
                                  output logic [31:0] val);
    haz = 1'b0;
    val = rf_mem[a];
    if (a == 5'd0) begin
      val = 32'd0;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      if (fwe[i] && frd[i] == a) begin
        haz = fpend[i];
        val = fdat[i];
        return;
      end
    end
  endfunction

  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc,
                                    output logic haz);
    bundle_t     b;
    int          sins;
    logic        u1, u2, h1, h2;
    logic [31:0] v1, v2;
    sins   = $signed(ins);
    u1     = 1'b0;
    u2     = 1'b0;
    b      = '0;
    b.pc   = pc;
    b.opc  = ins[6:0];
    b.f3   = ins[14:12];
    b.rd   = ins[11:7];
    case (ins[6:0])
      7'h37, 7'h17: b.imm = ins & 32'hFFFF_F000;
      7'h6F: b.imm = 32'((sins >>> 31) << 20) | (32'(ins[19:12]) << 12)
                   | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      7'h67, 7'h03: begin
        u1 = 1'b1;
        b.imm = 32'(sins >>> 20);
      end
      7'h13: begin
        u1 = 1'b1;
        b.imm = 32'(sins >>> 20);
        b.diff = ins[30];
      end
      7'h63: begin
        u1 = 1'b1;
        u2 = 1'b1;
        b.rd = 5'd0;
        b.imm = 32'((sins >>> 31) << 12) | (32'(ins[7]) << 11)
              | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      7'h23: begin
        u1 = 1'b1;
        u2 = 1'b1;
        b.rd = 5'd0;
        b.imm = 32'((sins >>> 25) << 5) | 32'(ins[11:7]);
      end
      7'h33: begin
        u1 = 1'b1;
        u2 = 1'b1;
        b.diff = ins[30];
      end
      default: begin
        b.ill = 1'b1;
        b.rd  = 5'd0;
        b.f3  = 3'd0;
      end
    endcase
    b.rs1 = u1 ? ins[19:15] : 5'd0;
    b.rs2 = u2 ? ins[24:20] : 5'd0;
    resolve(b.rs1, h1, v1);
    resolve(b.rs2, h2, v2);
    b.op1 = v1;
    b.op2 = v2;
    haz = h1 || h2;
    return b;
  endfunction

  function automatic logic [31:0] gen_ins();
    logic [6:0]  ops[12];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
            7'h7F, 7'h0B, 7'h73};
    r = $urandom();
    r[6:0]   = ops[$urandom_range(0, 11)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_idle();
    bus.rdy_in   = 1'b1;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc    = 32'd0;
    bus.if_ins   = 32'd0;
    bus.ex_ready = 1'b1;
    for (int i = 0; i < NF; i++) begin
      fwe[i]   = 1'b0;
      frd[i]   = 5'd0;
      fdat[i]  = 32'd0;
      fpend[i] = 1'b0;
    end
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_ins   = ins;
    bus.if_pc    = pc;
  endtask

  task automatic test_reset();
    logic h;
    bundle_t e;
    set_idle();
    rst_in = 1'b1;
    offer(32'h0050_0093, 32'h40);
    e = model(32'h0050_0093, 32'h40, h);
    #1;
    n_tests++;
    if (bus.id_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_id_ready: got %b expected 0", bus.id_ready);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ex_valid: got %b expected 0", bus.ex_valid);
    end
    n_tests++;
    if (act !== bundle_t'(0)) begin
      n_fail++;
      $display("FAIL reset_bundle: got %h expected 0 (offered pc %h)", act, e.pc);
    end
    rst_in = 1'b0;
    set_idle();
    tick();
  endtask

  task automatic test_addi();
    logic h;
    bundle_t e;
    set_idle();
    offer(32'h0050_0093, 32'h100);
    e = model(32'h0050_0093, 32'h100, h);
    #1;
    n_tests++;
    if (bus.id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL addi_id_ready: got %b expected 1", bus.id_ready);
    end
    tick();
    bus.if_valid = 1'b0;
    n_tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd1 || bus.ex_imm !== 32'd5 ||
        bus.ex_op1 !== 32'd0 || bus.ex_opcode !== 7'h13) begin
      n_fail++;
      $display("FAIL addi_fields: got v=%b rd=%0d imm=%h op1=%h opc=%h expected v=1 rd=1 imm=5 op1=0 opc=13",
               bus.ex_valid, bus.ex_rd, bus.ex_imm, bus.ex_op1, bus.ex_opcode);
    end
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL addi_bundle: got %h expected %h", act, e);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_bubble: got %b expected 0", bus.ex_valid);
    end
  endtask

  task automatic test_forward();
    set_idle();
    rf_mem[1] = 32'h7;
    rf_mem[2] = 32'h1234;
    fwe[0] = 1'b1; frd[0] = 5'd2; fdat[0] = 32'hAA; fpend[0] = 1'b0;
    fwe[1] = 1'b1; frd[1] = 5'd2; fdat[1] = 32'hBB; fpend[1] = 1'b0;
    offer(32'h0011_01B3, 32'h104);
    tick();
    bus.if_valid = 1'b0;
    n_tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_op1 !== 32'hAA || bus.ex_op2 !== 32'h7 ||
        bus.ex_rd !== 5'd3) begin
      n_fail++;
      $display("FAIL fwd_priority: got v=%b op1=%h op2=%h rd=%0d expected v=1 op1=aa op2=7 rd=3",
               bus.ex_valid, bus.ex_op1, bus.ex_op2, bus.ex_rd);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    offer(32'h0050_0093, 32'h200);
    tick();
    fwe[0] = 1'b1; frd[0] = 5'd2; fdat[0] = 32'hDEAD; fpend[0] = 1'b1;
    offer(32'h0011_01B3, 32'h204);
    #1;
    n_tests++;
    if (bus.id_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_stall_ready: got %b expected 0", bus.id_ready);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_bubble: got %b expected 0", bus.ex_valid);
    end
    fpend[0] = 1'b0;
    fdat[0]  = 32'h55;
    #1;
    n_tests++;
    if (bus.id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_resume_ready: got %b expected 1", bus.id_ready);
    end
    tick();
    bus.if_valid = 1'b0;
    n_tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_op1 !== 32'h55 || bus.ex_pc !== 32'h204) begin
      n_fail++;
      $display("FAIL lu_result: got v=%b op1=%h pc=%h expected v=1 op1=55 pc=204",
               bus.ex_valid, bus.ex_op1, bus.ex_pc);
    end
    set_idle();
    tick();
  endtask

  task automatic test_backpressure();
    logic h;
    bundle_t ea, eb;
    set_idle();
    offer(32'h0050_0093, 32'h300);
    ea = model(32'h0050_0093, 32'h300, h);
    tick();
    bus.ex_ready = 1'b0;
    offer(32'h00A0_0113, 32'h304);
    eb = model(32'h00A0_0113, 32'h304, h);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (bus.id_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_id_ready[%0d]: got %b expected 0", c, bus.id_ready);
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b1 || act !== ea) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 %h", c, bus.ex_valid, act, ea);
      end
    end
    bus.ex_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b expected 1", bus.id_ready);
    end
    tick();
    bus.if_valid = 1'b0;
    n_tests++;
    if (bus.ex_valid !== 1'b1 || act !== eb) begin
      n_fail++;
      $display("FAIL bp_next: got v=%b %h expected v=1 %h", bus.ex_valid, act, eb);
    end
    tick();
  endtask

  task automatic test_store_illegal();
    set_idle();
    offer(32'hFE20_AE23, 32'h400);
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 32'hFFFF_FFFC || bus.ex_rd !== 5'd0 ||
        bus.ex_rs1 !== 5'd1 || bus.ex_rs2 !== 5'd2 || bus.ex_funct3 !== 3'd2) begin
      n_fail++;
      $display("FAIL sw_decode: got v=%b imm=%h rd=%0d rs1=%0d rs2=%0d f3=%0d expected v=1 imm=fffffffc rd=0 rs1=1 rs2=2 f3=2",
               bus.ex_valid, bus.ex_imm, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_funct3);
    end
    offer(32'hFFFF_FFFF, 32'h404);
    tick();
    bus.if_valid = 1'b0;
    n_tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_illegal !== 1'b1 || bus.ex_rd !== 5'd0 ||
        bus.ex_imm !== 32'd0 || bus.ex_rs1 !== 5'd0 || bus.ex_funct3 !== 3'd0 ||
        bus.ex_diff !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_decode: got v=%b ill=%b rd=%0d imm=%h rs1=%0d f3=%0d diff=%b expected v=1 ill=1 rest 0",
               bus.ex_valid, bus.ex_illegal, bus.ex_rd, bus.ex_imm, bus.ex_rs1, bus.ex_funct3, bus.ex_diff);
    end
    tick();
  endtask

  task automatic test_flush();
    set_idle();
    offer(32'h0050_0093, 32'h500);
    tick();
    bus.flush = 1'b1;
    offer(32'h00A0_0113, 32'h504);
    #1;
    n_tests++;
    if (bus.id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_id_ready: got %b expected 1", bus.id_ready);
    end
    tick();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    n_tests++;
    if (bus.ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_valid: got %b expected 0", bus.ex_valid);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b0 || bus.ex_pc === 32'h504) begin
      n_fail++;
      $display("FAIL flush_dropped: got v=%b pc=%h expected v=0 pc!=504", bus.ex_valid, bus.ex_pc);
    end
    // flush together with a hazard: flush wins
    offer(32'h0050_0093, 32'h508);
    tick();
    fwe[0] = 1'b1; frd[0] = 5'd2; fpend[0] = 1'b1;
    offer(32'h0011_01B3, 32'h50C);
    bus.flush = 1'b1;
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_hazard: got %b expected 0", bus.ex_valid);
    end
    set_idle();
    tick();
  endtask

  task automatic test_hold_and_reset();
    logic h;
    bundle_t e;
    set_idle();
    offer(32'h0050_0093, 32'h600);
    e = model(32'h0050_0093, 32'h600, h);
    tick();
    bus.rdy_in = 1'b0;
    bus.flush  = 1'b1;
    offer(32'h00A0_0113, 32'h604);
    #1;
    n_tests++;
    if (bus.id_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_id_ready: got %b expected 0", bus.id_ready);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b1 || act !== e) begin
      n_fail++;
      $display("FAIL hold_state: got v=%b %h expected v=1 %h", bus.ex_valid, act, e);
    end
    bus.rdy_in   = 1'b1;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    n_tests++;
    if (bus.ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midstream: got %b expected 0", bus.ex_valid);
    end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    logic    mv, h, haz, exp_rdy;
    bundle_t mb, eb;
    set_idle();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    mv = 1'b0;
    mb = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int r = 1; r < 4; r++) rf_mem[r] = $urandom();
      for (int i = 0; i < NF; i++) begin
        fwe[i]   = 1'($urandom_range(0, 1));
        frd[i]   = 5'($urandom_range(0, 3));
        fdat[i]  = $urandom();
        fpend[i] = ($urandom_range(0, 3) == 0);
      end
      bus.if_valid = ($urandom_range(0, 3) != 0);
      bus.if_ins   = gen_ins();
      bus.if_pc    = $urandom();
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      bus.rdy_in   = ($urandom_range(0, 7) != 0);
      bus.flush    = ($urandom_range(0, 15) == 0);
      #1;
      eb = model(bus.if_ins, bus.if_pc, h);
      haz = bus.if_valid && h;
      exp_rdy = bus.rdy_in && !haz && (!mv || bus.ex_ready);
      n_tests++;
      if (bus.id_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_id_ready[%0d]: got %b expected %b ins=%h", c, bus.id_ready, exp_rdy, bus.if_ins);
      end
      if (bus.rdy_in) begin
        if (bus.flush) mv = 1'b0;
        else if (!mv || bus.ex_ready) begin
          if (bus.if_valid && !haz) begin
            mv = 1'b1;
            mb = eb;
          end else begin
            mv = 1'b0;
          end
        end
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== mv) begin
        n_fail++;
        $display("FAIL rnd_valid[%0d]: got %b expected %b", c, bus.ex_valid, mv);
      end
      if (mv) begin
        n_tests++;
        if (act !== mb) begin
          n_fail++;
          $display("FAIL rnd_bundle[%0d]: got %h expected %h", c, act, mb);
        end
      end
    end
    set_idle();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int r = 0; r < 32; r++) rf_mem[r] = $urandom();
    rst_in = 1'b1;
    set_idle();
    test_reset();
    test_addi();
    test_forward();
    test_load_use();
    test_backpressure();
    test_store_illegal();
    test_flush();
    test_hold_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction-decode stage. Decodes one instruction per cycle from IF and reads the register file. Resolves operands through a parametrised set of forwarding channels and detects load-use hazards. Presents the decoded bundle to EX through a valid/ready pipeline register, replacing the old combinational decoder and its coarse stall output with per-stage handshakes, flush and bubble insertion.

## Interface
- XLEN, 32, datapath width; imm, pc and operand widths.
- NUM_FWD, 2, forwarding channels. Channel 0 is youngest (EX) and has highest priority.
- REG_AW, 5, register address width.

Clocking is one clock, `clk_in`. `rst_in` is synchronous and active-high.

- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; when 0, all state holds
- flush  in  1  kill in-flight decode and output register (branch redirect)
- if_valid  in  1  IF offers instruction
- if_pc  in  XLEN  instruction PC
- if_ins  in  32  instruction word
- id_ready  out  1  stage accepts instruction this cycle
- rf_re1 / rf_re2  out  1  register-file read enables
- rf_addr1 / rf_addr2  out  REG_AW  read addresses (combinational from if_ins)
- rf_data1 / rf_data2  in  XLEN  read data, same cycle
- fwd_we  in  NUM_FWD  channel writes a register
- fwd_rd  in  NUM_FWD*REG_AW  packed destination addresses
- fwd_data  in  NUM_FWD*XLEN  packed result data
- fwd_pending  in  NUM_FWD  channel result not yet available (load in flight)
- ex_ready  in  1  EX accepts bundle
- ex_valid  out  1  bundle valid
- ex_pc  out  XLEN
- ex_rs1 / ex_rs2  out  REG_AW
- ex_op1 / ex_op2  out  XLEN  resolved operands
- ex_rd  out  REG_AW
- ex_imm  out  XLEN
- ex_opcode  out  7
- ex_funct3  out  3
- ex_diff  out  1  ins[30] for OP/OP-IMM, else 0
- ex_illegal  out  1  unknown opcode

## Operation
Decode is combinational from if_ins, for opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP:
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP. rs2 is used by BRANCH, STORE and OP. An unused rs field is driven as 0 with its read enable at 0.
- rd is forced to 0 for BRANCH and STORE.
- Immediates are sign-extended to XLEN in the U/J/I/B/S formats. OP has imm 0.
- Any other opcode decodes as: ex_illegal=1, rd=0, rs=0, imm=0, funct3=0, diff=0. It still flows as a valid bundle.

Operand resolution, per source s with address a≠0:
- Take the lowest-index channel i with fwd_we[i] && fwd_rd[i]==a.
- If it exists and fwd_pending[i]=1, a hazard is raised.
- If it exists and is not pending, the operand is fwd_data[i].
- If no channel matches, the operand is rf_data.
- a==0 always resolves to 0 with no hazard.

Handshake:
- hazard = if_valid && any used source raises a hazard.
- id_ready = rdy_in && !hazard && (!ex_valid || ex_ready).
- Transfer occurs when if_valid && id_ready; the output register loads the bundle and ex_valid becomes 1.
- When the output register is free or consumed (!ex_valid || ex_ready) and no transfer occurs (no input, or hazard), ex_valid goes to 0. This is a bubble.
- While ex_valid && !ex_ready, all ex_* outputs hold stable.

Priority per cycle: rst_in > !rdy_in (hold everything) > flush > normal.
- flush: ex_valid becomes 0 next cycle.
- flush: the instruction offered this cycle is dropped; id_ready is still reported per the formula, and IF discards it.

## Timing
- Reset: all ex_* outputs, ex_valid and ex_illegal are 0 on the first edge with rst_in=1.
- id_ready and rf_* are combinational. During reset, id_ready is 0.
- Latency: an instruction accepted at edge N appears on ex_* after edge N.
- Throughput is 1 per cycle when ex_ready is held high.
- Load-use costs exactly one bubble per pending cycle. Stall lasts while fwd_pending matches.
- rdy_in=0 mid-stall: hazard state is re-evaluated from live inputs on resume; no internal state beyond the output register.
- Reset asserted mid-stream clears ex_valid regardless of ex_ready.
- Simultaneous flush and hazard: flush wins; ex_valid=0.

## Test plan
- Reset, then stream ADDI x1,x0,5 (0x00500093) with ex_ready=1 → next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_op1=0, ex_opcode=0x13.
- ADD x3,x2,x1 (0x001101B3) with ch0 {we=1, rd=2, data=0xAA, pending=0}, ch1 {we=1, rd=2, data=0xBB} and rf_data2=0x7 → ex_op1=0xAA (ch0 wins over ch1 and RF) and ex_op2=0x7.
- Load-use: ADD x3,x2,x1 offered with ch0 {rd=2, pending=1} for 1 cycle, then pending=0 with data=0x55 → id_ready=0 in the first cycle, one bubble (ex_valid=0), then the bundle with ex_op1=0x55.
- Backpressure: ex_ready=0 for 3 cycles with a valid bundle → ex_* are unchanged and id_ready=0. ex_ready=1 → the next instruction loads in that cycle.
- SW x2,-4(x1) (0xFE20AE23) → ex_imm=0xFFFFFFFC, ex_rd=0. Opcode 0x7F → ex_illegal=1, ex_valid=1.
- flush asserted with ex_valid=1 and a new instruction offered → ex_valid=0 next cycle, and the offered instruction never appears on ex_*.
